// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, shift FSM states, default width.
// Used by the single-cycle alu and by the iterative shift unit.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One shift step: shifts the operand by a small amount (1..4).
// All zero-fill and sign-fill behaviour of the shift unit lives here.
module shift_step
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] opnd_i,
    input  logic [3:0]      op_i,
    input  logic [2:0]      amt_i,
    output logic [XLEN-1:0] res_o
);

    // Select the shift flavour; SRA replicates the operand MSB.
    always_comb begin
        res_o = opnd_i;
        case (op_i)
            OP_SLL:  res_o = opnd_i << amt_i;
            OP_SRL:  res_o = opnd_i >> amt_i;
            OP_SRA:  res_o = $unsigned($signed(opnd_i) >>> amt_i);
            default: res_o = opnd_i;
        endcase
    end

endmodule

// File: rtl/alu_shift_seq.sv
// Iterative SLL/SRL/SRA unit with valid/ready request and response channels.
// Define ALU_SHIFT_FAST_EN to shift up to four positions per cycle
// instead of one; results are identical, only latency changes.
//
// Handshake: a transfer happens on a channel in every cycle where both
// valid and ready are high at the rising edge. req_ready depends only on the
// state register (and rst_n); rsp_* are held stable while rsp_valid is high
// and rsp_ready is low.
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rd,
    output logic            rsp_err,
    output logic [1:0]      dbg_state_o
);

    shift_state_t    state_q, state_d;
    logic [SHW-1:0]  count_q;
    logic [XLEN-1:0] data_q;
    logic [3:0]      op_q;
    logic            err_q;
    logic [2:0]      step_amt;
    logic [XLEN-1:0] step_res;
    logic            accept;
    logic            unused_rs2;

    // Only the low SHW bits of rs2 carry the shift amount.
    assign unused_rs2 = ^req_rs2[XLEN-1:SHW];

    assign accept = req_valid && req_ready;

`ifdef ALU_SHIFT_FAST_EN
    // Take four positions per cycle until fewer than four remain.
    always_comb begin
        step_amt = 3'd4;
        if (count_q < SHW'(4)) step_amt = count_q[2:0];
    end
`else
    // Single-bit stepping: the step amount is a constant one.
    always_comb begin
        step_amt = 3'd1;
    end
`endif

    shift_step #(.XLEN(XLEN)) u_step (
        .opnd_i (data_q),
        .op_i   (op_q),
        .amt_i  (step_amt),
        .res_o  (step_res)
    );

    // Next-state logic for IDLE -> (SHIFT) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_shift_op(req_op) || (req_rs2[SHW-1:0] == '0))
                        state_d = DONE;
                    else
                        state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (count_q == SHW'(step_amt)) state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand, count and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            data_q  <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= req_op;
                        count_q <= req_rs2[SHW-1:0];
                        if (is_shift_op(req_op)) begin
                            data_q <= req_rs1;
                            err_q  <= 1'b0;
                        end else begin
                            data_q <= '0;
                            err_q  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    data_q  <= step_res;
                    count_q <= count_q - SHW'(step_amt);
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = rst_n && (state_q == IDLE);
    assign rsp_valid   = (state_q == DONE);
    assign rsp_rd      = data_q;
    assign rsp_err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/alu_shift_seq.md
# alu_shift_seq

Iterative shift unit that executes SLL/SRL/SRA requests from the ALU issue side over a valid/ready request channel. Results return on a valid/ready response channel. The shift is computed one position per cycle, or four with the fast option, in place of a combinational barrel shifter. It sits beside the single-cycle `alu` in the execute stage and serves the same 4-bit op encoding and rs1/rs2/rd operand convention.

## Interface
- `XLEN`, 32: operand/result width; must be a power of two ≥ 8.
- `SHW`, $clog2(XLEN): shift-amount width, derived; not overridden.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request.
- `req_op`  in  4: operation code, from `alu_pkg`.
- `req_rs1`  in  XLEN: value to shift.
- `req_rs2`  in  XLEN: shift amount in bits [SHW-1:0]; upper bits ignored.
- `rsp_valid`  out  1: result present.
- `rsp_ready`  in  1: consumer takes result.
- `rsp_rd`  out  XLEN: shift result.
- `rsp_err`  out  1: op was not a shift op.

## Operation
- Op codes: OP_SLL=4'b1000, OP_SRL=4'b1001, OP_SRA=4'b1010. Every other code is illegal.
- FSM states:
  - IDLE: `req_ready`=1.
  - SHIFT: shifting in progress.
  - DONE: `rsp_valid`=1.
  - `req_ready`=0 in SHIFT and DONE.
- Accept: `req_valid && req_ready` latches operand, op, and count = rs2[SHW-1:0].
- From IDLE on accept:
  - Illegal op → DONE with rd=0, err=1.
  - count=0 → DONE with rd=rs1, err=0.
  - Otherwise → SHIFT.
- SHIFT step: each cycle shifts by step = min(count, STEP) and decrements count by step. STEP=1, or 4 with the fast option.
  - SLL and SRL fill with zeros.
  - SRA replicates operand bit XLEN-1.
  - When the new count is 0, go to DONE.
- DONE: `rsp_rd`/`rsp_err` are held stable while `rsp_valid && !rsp_ready`. On `rsp_ready` → IDLE.
- No overlap. A new request cannot be accepted in the DONE handshake cycle. The earliest accept is the following cycle.
- Input stability: `req_*` may change freely after accept. Only the latched copies are used.
- Reset values (after a clock edge with `rst_n`=0): state=IDLE, `rsp_valid`=0, `rsp_rd`=0, `rsp_err`=0, count=0.
- `req_ready`=0 while `rst_n` is low.
- Reset mid-operation (SHIFT or DONE) aborts the operation. No response is ever produced for the aborted request.

## Timing
- Accept at edge N. `rsp_valid` rises at edge N+1+ceil(shamt/STEP).
  - shamt=0 or illegal op: N+1.
  - shamt=31 with STEP=1: N+32.
  - shamt=31 with STEP=4: N+9.
- `rsp_rd`, `rsp_err`, and `rsp_valid` are registered outputs.
- `req_ready` is decoded from the state register only. There is no combinational path from `req_valid` or `rsp_ready`.
- Throughput: at most one request per (latency+1) cycles with `rsp_ready` tied high.

## Configuration
- `ALU_SHIFT_FAST_EN` defined: STEP=4.
  - Step logic selects a shift of 1–4 per cycle.
  - Latency is as above with STEP=4.
  - Results are identical.
- Not defined: STEP=1. Only single-bit shift hardware is present.

## Structure
- `alu_pkg` holds:
  - Op localparams OP_SLL/OP_SRL/OP_SRA, shared with `alu`.
  - `shift_state_t` enum {IDLE, SHIFT, DONE}.
  - Default XLEN constant.
- Sub-module `shift_step`: combinational. Inputs are operand, op, and amount (1..STEP). Output is the shifted value. It is instantiated once, and all fill and sign logic lives there.
- `alu_shift_seq` holds the FSM, the count register, the operand register, and the handshake.

## Test plan
- SLL, rs1=32'h0000_0001, rs2=31, `rsp_ready`=1 → rd=32'h8000_0000, `rsp_valid` at N+32 (N+9 with fast).
- SRA and SRL, rs1=32'hfa17_0000, rs2=16 → SRA rd=32'hffff_fa17, SRL rd=32'h0000_fa17, both at N+17 (N+5 with fast).
- rs2=32'h0000_0020 (shamt 0), SLL, rs1=32'h0a17_0000 → rd=32'h0a17_0000, err=0 at N+1.
- Illegal op 4'b0110, any operands → rd=0, err=1 at N+1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in DONE → rd/err stable, `req_ready`=0. A second request held on `req_valid` is accepted exactly one cycle after the response handshake.
- `rst_n`=0 for one edge during SHIFT → next cycle `rsp_valid`=0, `rsp_rd`=0. After release, `req_ready`=1, and no stale response ever appears.
